// File: rtl/can_wb_host_seq.sv
// Wishbone initiator that runs one CAN frame exchange per request: TX setup, send, poll, RX readback.
// Define CAN_WB_SEQ_IDCHK_EN to flag a received ID that differs from the requested one (status 3).
module can_wb_host_seq #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT  = 16,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_id,
  input  logic [3:0]  req_len,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [10:0] rsp_id,
  output logic [7:0]  rsp_data0,
  output logic [7:0]  rsp_data1,
  output logic [1:0]  rsp_status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [3:0] {
    StIdle, StWId, StWLen, StWD0, StWD1, StWCmd, StPoll, StRId, StRD0, StRD1, StRAck, StResp
  } state_e;

  state_e      state_q, state_d, launch_st;
  logic        launch;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [7:0]  wdog_q, wdog_d, poll_q, poll_d;
  logic [10:0] id_q, id_d, rid_q, rid_d;
  logic [3:0]  len_q, len_d;
  logic [31:0] d0_q, d0_d, d1_q, d1_d;
  logic [7:0]  rd0_q, rd0_d, rd1_q, rd1_d;
  logic [1:0]  st_q, st_d;
  logic        unused_dat;

  assign unused_dat = ^wb_dat_i[31:11];

  function automatic logic [7:0] reg_off(state_e s);
    case (s)
      StWId:   return 8'h08;
      StWLen:  return 8'h0C;
      StWD0:   return 8'h10;
      StWD1:   return 8'h14;
      StWCmd:  return 8'h00;
      StPoll:  return 8'h04;
      StRId:   return 8'h18;
      StRD0:   return 8'h20;
      StRD1:   return 8'h24;
      StRAck:  return 8'h1C;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wdog_d    = wdog_q;
    poll_d    = poll_q;
    id_d      = id_q;
    len_d     = len_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    rid_d     = rid_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    st_d      = st_q;
    launch    = 1'b0;
    launch_st = StIdle;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          id_d      = req_id;
          len_d     = req_len;
          d0_d      = req_data0;
          d1_d      = req_data1;
          rid_d     = '0;
          rd0_d     = '0;
          rd1_d     = '0;
          st_d      = 2'd0;
          poll_d    = '0;
          state_d   = StWId;
          launch    = 1'b1;
          launch_st = StWId;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: begin
        // cyc low in an access state is the gap cycle: start this state's access
        if (!cyc_q) begin
          launch    = 1'b1;
          launch_st = state_q;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          case (state_q)
            StWId:  state_d = StWLen;
            StWLen: state_d = StWD0;
            StWD0:  state_d = StWD1;
            StWD1:  state_d = StWCmd;
            StWCmd: state_d = StPoll;
            StPoll: begin
              if (wb_dat_i[0]) begin
                state_d = StRId;
              end else begin
                poll_d = poll_q + 8'd1;
                if (poll_d == 8'(POLL_LIMIT)) begin
                  st_d    = 2'd1;
                  state_d = StResp;
                end
              end
            end
            StRId: begin
              rid_d   = wb_dat_i[10:0];
              state_d = StRD0;
            end
            StRD0: begin
              rd0_d   = wb_dat_i[7:0];
              state_d = StRD1;
            end
            StRD1: begin
              rd1_d   = wb_dat_i[7:0];
              state_d = StRAck;
            end
            StRAck: begin
              st_d    = 2'd0;
`ifdef CAN_WB_SEQ_IDCHK_EN
              if (rid_q != id_q) st_d = 2'd3;
`endif
              state_d = StResp;
            end
            default: ;
          endcase
        end else if (wdog_q == 8'(ACK_TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          st_d    = 2'd2;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
    endcase

    // id/len/data *_d already hold the freshly accepted request when launching from idle
    if (launch) begin
      cyc_d  = 1'b1;
      wdog_d = '0;
      adr_d  = BASE_ADDR + {24'b0, reg_off(launch_st)};
      we_d   = launch_st inside {StWId, StWLen, StWD0, StWD1, StWCmd};
      case (launch_st)
        StWId:   dat_d = {21'b0, id_d};
        StWLen:  dat_d = {28'b0, len_d};
        StWD0:   dat_d = d0_d;
        StWD1:   dat_d = d1_d;
        StWCmd:  dat_d = 32'h2;
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      wdog_q  <= '0;
      poll_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      rid_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      wdog_q  <= wdog_d;
      poll_q  <= poll_d;
      id_q    <= id_d;
      len_q   <= len_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      rid_q   <= rid_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      st_q    <= st_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rid_q;
  assign rsp_data0  = rd0_q;
  assign rsp_data1  = rd1_q;
  assign rsp_status = st_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;

endmodule

// File: tb/tb_can_wb_host_seq.sv
// Directed bench for can_wb_host_seq against a loopback CAN register-block responder.
module tb_can_wb_host_seq;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef CAN_WB_SEQ_IDCHK_EN
  localparam logic [1:0] IdMisStatus = 2'd3;
`else
  localparam logic [1:0] IdMisStatus = 2'd0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [10:0] req_id = '0, rsp_id;
  logic [3:0]  req_len = '0;
  logic [31:0] req_data0 = '0, req_data1 = '0;
  logic [7:0]  rsp_data0, rsp_data1;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  can_wb_host_seq #(.BASE_ADDR(BASE), .POLL_LIMIT(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_len(req_len), .req_data0(req_data0), .req_data1(req_data1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_status(rsp_status), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Responder controls, driven only by the stimulus block
  logic        hold0 = 1'b0;
  logic [31:0] nak_addr = 32'hFFFF_FFFF;
  logic [31:0] id_off = '0;

  // Responder state and access log
  logic        ack_r = 1'b0, rx_ready = 1'b0;
  logic [31:0] tx_id = '0, tx_len = '0, tx_d0 = '0, tx_d1 = '0, rx_id = '0, rd, off;
  logic [31:0] log_adr [256];
  logic [31:0] log_dat [256];
  logic        log_we  [256];
  int          n_acc = 0, edge_cnt = 0, nak_cnt = 0;

  assign wb_ack_i = ack_r;
  assign wb_dat_i = rd;

  always_comb begin
    off = wb_adr_o - BASE;
    case (off)
      32'h04:  rd = {31'b0, rx_ready & ~hold0};
      32'h08:  rd = tx_id;
      32'h0C:  rd = tx_len;
      32'h10:  rd = tx_d0;
      32'h14:  rd = tx_d1;
      32'h18:  rd = rx_id;
      32'h1C:  rd = tx_len;
      32'h20:  rd = tx_d0;
      32'h24:  rd = tx_d1;
      default: rd = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (wb_stb_o && wb_adr_o == nak_addr) nak_cnt <= nak_cnt + 1;
    ack_r <= wb_cyc_o && wb_stb_o && !ack_r && (wb_adr_o != nak_addr);
    if (wb_cyc_o && wb_stb_o && ack_r) begin
      log_adr[n_acc] <= wb_adr_o;
      log_we[n_acc]  <= wb_we_o;
      log_dat[n_acc] <= wb_we_o ? wb_dat_o : wb_dat_i;
      n_acc <= n_acc + 1;
      if (wb_we_o) begin
        case (off)
          32'h00: if (wb_dat_o == 32'h2) begin rx_ready <= 1'b1; rx_id <= tx_id + id_off; end
          32'h08: tx_id  <= wb_dat_o;
          32'h0C: tx_len <= wb_dat_o;
          32'h10: tx_d0  <= wb_dat_o;
          32'h14: tx_d1  <= wb_dat_o;
          default: ;
        endcase
      end else if (off == 32'h1C) begin
        rx_ready <= 1'b0;
      end
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] len, input logic [31:0] d0,
                      input logic [31:0] d1, output int acc_edge);
    @(negedge clk);
    req_id = id; req_len = len; req_data0 = d0; req_data1 = d1; req_valid = 1'b1;
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 acc_edge = edge_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    check("cyc_after_accept", {31'b0, wb_cyc_o}, 32'd1);
  endtask

  task automatic wait_rsp(input int budget, output int at_edge);
    bit ok;
    ok = 1'b0;
    at_edge = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; at_edge = edge_cnt; end
    end
    check("rsp_arrives", {31'b0, ok}, 32'd1);
  endtask

  logic [7:0]  t1_off [10] = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h00, 8'h04, 8'h18, 8'h20, 8'h24, 8'h1C};
  logic        t1_we  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] t1_dat [10] = '{32'h123, 32'h8, 32'hAABBCC11, 32'h22, 32'h2,
                               32'h1, 32'h123, 32'hAABBCC11, 32'h22, 32'h8};

  initial begin
    int a, r, b, cnt;

    // Reset values
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_we_dat", wb_dat_o | {31'b0, wb_we_o}, 32'd0);
    check("rst_status", {30'b0, rsp_status}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loopback exchange: 10 accesses, response 29 edges after accept
    b = n_acc;
    send(11'h123, 4'd8, 32'hAABBCC11, 32'h0000_0022, a);
    wait_rsp(100, r);
    check("t1_latency", r - a, 32'd29);
    check("t1_rsp_id", {21'b0, rsp_id}, 32'h123);
    check("t1_rsp_d0", {24'b0, rsp_data0}, 32'h11);
    check("t1_rsp_d1", {24'b0, rsp_data1}, 32'h22);
    check("t1_status", {30'b0, rsp_status}, 32'd0);
    check("t1_n_acc", n_acc - b, 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_adr%0d", i), log_adr[b + i], BASE + {24'b0, t1_off[i]});
      check($sformatf("t1_we%0d", i), {31'b0, log_we[b + i]}, {31'b0, t1_we[i]});
      check($sformatf("t1_dat%0d", i), log_dat[b + i], t1_dat[i]);
    end
    check("t1_status_cleared", {31'b0, rx_ready}, 32'd0);

    // Stalled response: everything holds and a pending request waits
    req_id = 11'h055; req_len = 4'd2; req_data0 = 32'h0000_00A5; req_data1 = 32'h0000_005A;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_id", {21'b0, rsp_id}, 32'h123);
      check("hold_rsp_data", {16'b0, rsp_data0, rsp_data1}, 32'h1122);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_cyc", {31'b0, wb_cyc_o}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("exit_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("exit_req_ready", {31'b0, req_ready}, 32'd1);
    check("exit_cyc", {31'b0, wb_cyc_o}, 32'd0);
    @(posedge clk);
    #1 a = edge_cnt;
    check("req2_taken_ready", {31'b0, req_ready}, 32'd0);
    check("req2_taken_cyc", {31'b0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(100, r);
    check("t4_latency", r - a, 32'd29);
    check("t4_rsp", {rsp_status, 3'b0, rsp_id, rsp_data0, rsp_data1}, {2'd0, 3'b0, 11'h055, 16'hA55A});

    // Status never ready: four polls, then poll timeout
    hold0 = 1'b1;
    b = n_acc;
    send(11'h3A5, 4'd3, 32'h1, 32'h2, a);
    wait_rsp(100, r);
    check("t2_latency", r - a, 32'd26);
    check("t2_status", {30'b0, rsp_status}, 32'd1);
    check("t2_rsp_zero", {rsp_id, rsp_data0, rsp_data1}, 32'd0);
    check("t2_n_acc", n_acc - b, 32'd9);
    cnt = 0;
    for (int i = 0; i < 9; i++) if (log_adr[b + i] == BASE + 32'h04 && !log_we[b + i]) cnt++;
    check("t2_poll_reads", cnt, 32'd4);
    check("t2_last_adr", log_adr[b + 8], BASE + 32'h04);
    hold0 = 1'b0;

    // Ack withheld on the length write: watchdog abort after 8 cycles
    nak_addr = BASE + 32'h0C;
    b = n_acc;
    cnt = nak_cnt;
    send(11'h1F0, 4'd4, 32'h5, 32'h6, a);
    wait_rsp(100, r);
    check("t3_latency", r - a, 32'd11);
    check("t3_stb_cycles", nak_cnt - cnt, 32'd8);
    check("t3_status", {30'b0, rsp_status}, 32'd2);
    check("t3_n_acc", n_acc - b, 32'd1);
    check("t3_rsp_id", {21'b0, rsp_id}, 32'd0);
    cnt = 0;
    for (int i = b; i < n_acc; i++) if (log_adr[i] == BASE) cnt++;
    check("t3_no_cmd", cnt, 32'd0);
    nak_addr = 32'hFFFF_FFFF;

    // Reset while polling, then a clean exchange
    hold0 = 1'b1;
    send(11'h222, 4'd1, 32'h7, 32'h8, a);
    cnt = 0;
    for (int i = 0; i < 100 && cnt == 0; i++) begin
      @(negedge clk);
      if (wb_stb_o && wb_adr_o == BASE + 32'h04) cnt = 1;
    end
    check("t5_reached_poll", cnt, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("t5_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("t5_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold0 = 1'b0;
    send(11'h7FF, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, a);
    wait_rsp(100, r);
    check("t5_latency", r - a, 32'd29);
    check("t5_rsp", {rsp_status, 3'b0, rsp_id, rsp_data0, rsp_data1}, {2'd0, 3'b0, 11'h7FF, 16'h78F0});

    // Responder echoes a different ID
    id_off = 32'd1;
    send(11'h123, 4'd1, 32'h0000_00C3, 32'h0000_003C, a);
    wait_rsp(100, r);
    check("t6_rsp_id", {21'b0, rsp_id}, 32'h124);
    check("t6_status", {30'b0, rsp_status}, {30'b0, IdMisStatus});
    check("t6_data", {16'b0, rsp_data0, rsp_data1}, 32'hC33C);
    id_off = 32'd0;

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
